sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; successor to the 8x8 dual-clock FIFO, for same-domain buffering.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode.
- Storage is a register array indexed by binary pointers with one extra wrap bit.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- ADDR_W, 3, log2 of depth; DEPTH = 2**ADDR_W (ADDR_W>=1)
- AF_TH, 6, almost_full asserted when count >= AF_TH (1..DEPTH)
- AE_TH, 1, almost_empty asserted when count <= AE_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- w_en  in  1  write request
- data_in  in  DATA_W  write data
- r_en  in  1  read request
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_TH
- almost_empty  out  1  count <= AE_TH
- count  out  ADDR_W+1  number of stored words (0..DEPTH)
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync release):
  - wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0, data_out = 0.
  - Memory contents are not reset.
- Accept rules:
  - wr_ok = w_en & !full.
  - rd_ok = r_en & !empty.
  - Flags are evaluated from the registered count at the start of the cycle.
- Write: on wr_ok, mem[wptr[ADDR_W-1:0]] <= data_in, wptr <= wptr+1 (modulo 2**(ADDR_W+1)).
- Read: on rd_ok, rptr <= rptr+1 (same modulo).
- Count update:
  - count += 1 on wr_ok only.
  - count -= 1 on rd_ok only.
  - Unchanged when both or neither occur.
- Flags: full/empty/almost_* are decoded from the registered count, so they update in the cycle after the accepting edge. No combinational path from w_en/r_en to any flag.
- Simultaneous read+write:
  - When 0 < count < DEPTH: both accepted, count unchanged.
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set.
- Pointer wrap: the extra MSB distinguishes full from empty; count always equals wptr - rptr (ADDR_W+1 bits).
- FWFT=0:
  - On rd_ok, data_out <= mem[rptr] at that edge: data visible 1 cycle after r_en.
  - data_out holds its last value otherwise, including when empty.
- FWFT=1:
  - data_out = mem[rptr[ADDR_W-1:0]] combinationally when !empty, else 0.
  - r_en with !empty pops the displayed word; the next word appears after the edge.
  - A word written into an empty FIFO is visible the cycle after the write edge, once empty has deasserted.
- Error flags:
  - overflow set on w_en & full; underflow set on r_en & empty.
  - Both cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Rejected operations never alter pointers, count or memory.
- Reset mid-operation: immediate return to reset state; in-flight data discarded; the first write after release lands at address 0.

Test Plan:
- Defaults (DATA_W=8, ADDR_W=3, FWFT=0):
  - Write 0x01..0x08 on 8 consecutive cycles -> count steps 1..8.
  - almost_empty drops when count reaches 2; almost_full rises when count reaches 6; full=1 when count=8, empty=0.
  - Read 8 cycles -> data_out 0x01..0x08, each 1 cycle after its r_en; empty=1 and count=0 after the last read.
- Full FIFO:
  - w_en with data_in=0xAA -> overflow=1, count stays 8, and the next 8 reads contain no 0xAA.
  - err_clr pulse -> overflow=0.
- Empty FIFO:
  - r_en -> underflow=1, data_out unchanged, count=0.
  - r_en together with err_clr in the same cycle -> underflow stays 1.
- Wrap and simultaneous access:
  - Pre-fill with 4 words, then 20 cycles of simultaneous w_en/r_en with incrementing data.
  - Required: count stays 4, output order strictly incrementing, pointers wrap past 15 without error flags.
- FWFT=1:
  - Write 0x5C into an empty FIFO -> the next cycle empty=0 and data_out=0x5C without r_en.
  - r_en -> empty=1, data_out=0.
- Async reset mid-stream:
  - Assert rst between clock edges while count=5 -> outputs take reset values immediately.
  - After release, write 0x11 then read -> data_out=0x11.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow error flags and an
// optional first-word-fall-through read mode.
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   w_en         in   write request
//   data_in      in   write data [DATA_W-1:0]
//   r_en         in   read request
//   data_out     out  read data [DATA_W-1:0]
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_TH
//   almost_empty out  count <= AE_TH
//   count        out  stored words [ADDR_W:0]
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//   err_clr      in   synchronous clear of overflow/underflow
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int AF_TH  = 6,
    parameter int AE_TH  = 1,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF_TH = (ADDR_W+1)'(AF_TH);
    localparam logic [ADDR_W:0] C_AE_TH = (ADDR_W+1)'(AE_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_unf;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Flags come only from the registered count, never from w_en/r_en.
    assign full         = (r_count == C_DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= C_AF_TH);
    assign almost_empty = (r_count <= C_AE_TH);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

    assign w_wr_ok = w_en & ~full;
    assign w_rd_ok = r_en & ~empty;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors: a set in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_en & full) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (r_en & empty) begin
                r_unf <= 1'b1;
            end else if (err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; zero while empty.
            assign data_out = empty ? '0 : r_mem[r_rptr[ADDR_W-1:0]];
        end else begin : g_reg
            logic [DATA_W-1:0] r_dout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_en = 1'b0;
    logic              r_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    logic [DATA_W-1:0] dout0, dout1;
    logic              full0, empty0, af0, ae0, ovf0, unf0;
    logic              full1, empty1, af1, ae1, ovf1, unf1;
    logic [ADDR_W:0]   cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of words plus the sticky flags and the
    // last-read word of the registered-read variant.
    logic [DATA_W-1:0] mq[$];
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    logic [DATA_W-1:0] m_dout0 = '0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0),
        .err_clr(err_clr)
    );

    sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1),
        .err_clr(err_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout0 = '0;
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        int  n;
        logic was_full, was_empty;
        n = mq.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (r && !was_empty) m_dout0 = mq.pop_front();
        if (w && !was_full) mq.push_back(d);
        if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count0", int'(cnt0), n);
        chk("count1", int'(cnt1), n);
        chk("full0", int'(full0), int'(n == DEPTH));
        chk("full1", int'(full1), int'(n == DEPTH));
        chk("empty0", int'(empty0), int'(n == 0));
        chk("empty1", int'(empty1), int'(n == 0));
        chk("afull0", int'(af0), int'(n >= AF_TH));
        chk("afull1", int'(af1), int'(n >= AF_TH));
        chk("aempty0", int'(ae0), int'(n <= AE_TH));
        chk("aempty1", int'(ae1), int'(n <= AE_TH));
        chk("ovf0", int'(ovf0), int'(m_ovf));
        chk("ovf1", int'(ovf1), int'(m_ovf));
        chk("unf0", int'(unf0), int'(m_unf));
        chk("unf1", int'(unf1), int'(m_unf));
        chk("dout_reg", int'(dout0), int'(m_dout0));
        chk("dout_fwft", int'(dout1), (n == 0) ? 0 : int'(mq[0]));
    endtask

    // Drive on the falling edge, let the rising edge act, check 1 ns later.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        @(negedge clk);
        w_en = w; data_in = d; r_en = r; err_clr = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [DATA_W-1:0] v;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x01..0x08
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, 1'b0);
            chk("fill_count", int'(cnt0), i);
            if (i == 2) chk("ae_drop", int'(ae0), 0);
            if (i == 6) chk("af_rise", int'(af0), 1);
        end
        chk("full_lit", int'(full0), 1);
        chk("empty_lit", int'(empty0), 0);

        // Write while full
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_lit", int'(ovf0), 1);
        chk("ovf_count", int'(cnt0), 8);

        // Drain: data appears one cycle after each r_en
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", int'(dout0), i);
        end
        chk("drain_empty", int'(empty0), 1);
        chk("drain_count", int'(cnt0), 0);

        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(ovf0), 0);

        // Read while empty, then set-vs-clear in one cycle
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_lit", int'(unf0), 1);
        chk("unf_dout_hold", int'(dout0), 8);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_set_wins", int'(unf0), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_clr", int'(unf0), 0);

        // Pre-fill 4, then 20 simultaneous read/write cycles
        v = 8'h20;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, v, 1'b0, 1'b0);
            v++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, v, 1'b1, 1'b0);
            v++;
            chk("simul_count", int'(cnt0), 4);
            chk("simul_order", int'(dout0), 8'h20 + i);
        end
        chk("simul_noerr", int'(ovf0 | unf0), 0);

        // Drain, then FWFT visibility of a word written into an empty FIFO
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        chk("fwft_empty", int'(empty1), 0);
        chk("fwft_data", int'(dout1), 8'h5C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_pop_empty", int'(empty1), 1);
        chk("fwft_pop_zero", int'(dout1), 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset mid-stream with five words stored
        step(1'b0, 8'h00, 1'b0, 1'b1);
        while (mq.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
        while (mq.size() < 5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("pre_rst_count", int'(cnt0), 5);
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_count_lit", int'(cnt0), 0);
        chk("rst_dout_lit", int'(dout0), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("post_rst_fwft", int'(dout1), 8'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data", int'(dout0), 8'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
